// File: rtl/retire_monitor.sv
// retire_monitor: observes RET_W retire slots per cycle and keeps saturating
// cycle / instruction / idle counters. It latches a final status on halt or on
// illegal retirement.
// Optional feature: define RETIRE_MON_WATCHDOG_EN to build a no-progress
// watchdog. After WD_CYCLES consecutive idle RUN cycles it ends the run with
// status 3.
module retire_monitor #(
    parameter int RET_W     = 2,
    parameter int CNT_W     = 32,
    parameter int WD_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic [RET_W-1:0]      retire_valid,
    input  logic [RET_W-1:0]      retire_halt,
    input  logic [RET_W-1:0]      retire_illegal,
    input  logic [RET_W*64-1:0]   retire_npc,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      instr_count,
    output logic [CNT_W-1:0]      idle_count,
    output logic [63:0]           last_npc,
    output logic [3:0]            status,
    output logic                  done
);

    localparam int SC_W = $clog2(RET_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;

    if (RET_W < 1 || RET_W > 8 || CNT_W < 8 || CNT_W > 64 || WD_CYCLES < 2) begin : g_param_err
        $error("retire_monitor: parameter out of range");
    end

    // blk[i] is set once some lower slot has terminated the run this cycle.
    // Every slot above that point is masked off.
    logic [RET_W:0]   blk;
    logic [RET_W-1:0] cnt_slot;
    logic [RET_W-1:0] term_slot;

    assign blk[0] = 1'b0;
    for (genvar i = 0; i < RET_W; i++) begin : g_slot
        assign cnt_slot[i]  = retire_valid[i] & ~blk[i];
        assign term_slot[i] = cnt_slot[i] & (retire_halt[i] | retire_illegal[i]);
        assign blk[i+1]     = blk[i] | term_slot[i];
    end

    logic [SC_W-1:0] n_cnt;
    logic [63:0]     npc_sel;
    logic            term_any;
    logic            term_ill;
    logic            wd_hit;

    // Count the retiring slots and pick the NPC of the highest counted slot.
    always_comb begin
        n_cnt   = '0;
        npc_sel = '0;
        for (int i = 0; i < RET_W; i++) begin
            n_cnt = n_cnt + SC_W'(cnt_slot[i]);
            if (cnt_slot[i]) npc_sel = retire_npc[i*64 +: 64];
        end
        term_any = blk[RET_W];
        term_ill = |(term_slot & retire_illegal);
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

`ifdef RETIRE_MON_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] streak;
    logic [WD_W-1:0] streak_nxt;

    assign streak_nxt = streak + WD_W'(1);
    assign wd_hit     = (n_cnt == '0) && (streak_nxt == WD_W'(WD_CYCLES));

    // Idle streak: held at zero outside RUN, so entering RUN starts it fresh.
    always_ff @(posedge clk) begin
        if (rst || state != S_RUN || n_cnt != '0) streak <= '0;
        else                                      streak <= streak_nxt;
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Main state machine. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst || (clear && state != S_IDLE)) begin
            state       <= S_IDLE;
            cycle_count <= '0;
            instr_count <= '0;
            idle_count  <= '0;
            last_npc    <= '0;
            status      <= 4'd0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_RUN;
                S_RUN: begin
                    cycle_count <= sat_add(cycle_count, CNT_W'(1));
                    instr_count <= sat_add(instr_count, CNT_W'(n_cnt));
                    if (n_cnt == '0) idle_count <= sat_add(idle_count, CNT_W'(1));
                    else             last_npc   <= npc_sel;
                    if (term_any) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        status <= term_ill ? 4'd2 : 4'd1;
                    end else if (wd_hit) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        status <= 4'd3;
                    end
                end
                S_DONE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_monitor.sv
// Scoreboard bench for retire_monitor. A reference model pushes the expected
// outputs for every clock edge. An independent monitor pops each entry and
// compares it after the edge.
module tb_retire_monitor;

    localparam int     RET_W = 2;
    localparam int     CNT_W = 8;
    localparam int     WD    = 16;
    localparam longint MAXC  = (longint'(1) << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start, clear;
    logic [RET_W-1:0]     retire_valid, retire_halt, retire_illegal;
    logic [RET_W*64-1:0]  retire_npc;
    logic [CNT_W-1:0]     cycle_count, instr_count, idle_count;
    logic [63:0]          last_npc;
    logic [3:0]           status;
    logic                 done;

    retire_monitor #(.RET_W(RET_W), .CNT_W(CNT_W), .WD_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .retire_valid(retire_valid), .retire_halt(retire_halt),
        .retire_illegal(retire_illegal), .retire_npc(retire_npc),
        .cycle_count(cycle_count), .instr_count(instr_count),
        .idle_count(idle_count), .last_npc(last_npc),
        .status(status), .done(done)
    );

    typedef struct {
        longint      cyc;
        longint      ins;
        longint      idl;
        logic [63:0] npc;
        int          st;
        bit          dn;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: mode 0 = idle, 1 = run, 2 = done
    int          m_mode = 0;
    longint      m_cyc = 0, m_ins = 0, m_idl = 0;
    logic [63:0] m_npc = '0;
    int          m_st = 0;
    int          m_streak = 0;

    function automatic longint sat(input longint x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    task automatic m_zero();
        m_mode = 0; m_cyc = 0; m_ins = 0; m_idl = 0;
        m_npc = '0; m_st = 0; m_streak = 0;
    endtask

    // Apply the rules to the inputs present before the coming edge.
    task automatic model_step();
        exp_t e;
        if (rst || (clear && m_mode != 0)) begin
            m_zero();
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_streak = 0; end
        end else if (m_mode == 1) begin
            int n = 0;
            int term = -1;
            for (int s = 0; s < RET_W; s++) begin
                if (retire_valid[s]) begin
                    n++;
                    m_npc = retire_npc[s*64 +: 64];
                    if (retire_halt[s] || retire_illegal[s]) begin term = s; break; end
                end
            end
            m_cyc = sat(m_cyc + 1);
            m_ins = sat(m_ins + n);
            if (n == 0) begin m_idl = sat(m_idl + 1); m_streak++; end
            else m_streak = 0;
            if (term >= 0) begin
                m_mode = 2;
                m_st = retire_illegal[term] ? 2 : 1;
            end
`ifdef RETIRE_MON_WATCHDOG_EN
            else if (m_streak >= WD) begin
                m_mode = 2;
                m_st = 3;
            end
`endif
        end
        e.cyc = m_cyc; e.ins = m_ins; e.idl = m_idl;
        e.npc = m_npc; e.st = m_st; e.dn = (m_mode == 2);
        q.push_back(e);
    endtask

    // Drive one cycle of stimulus, record the expectation, and return after the edge.
    task automatic step(input bit s, input bit c, input bit r,
                        input logic [1:0] v, input logic [1:0] h, input logic [1:0] il,
                        input logic [127:0] n);
        start = s; clear = c; rst = r;
        retire_valid = v; retire_halt = h; retire_illegal = il; retire_npc = n;
        model_step();
        @(posedge clk);
        #3;
    endtask

    task automatic idle_n(input int k);
        repeat (k) step(0, 0, 0, 2'b00, 2'b00, 2'b00, '0);
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compare the DUT with the oldest pending expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (cycle_count !== CNT_W'(e.cyc) || instr_count !== CNT_W'(e.ins) ||
                    idle_count !== CNT_W'(e.idl) || last_npc !== e.npc ||
                    status !== 4'(e.st) || done !== e.dn) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got cyc=%0d ins=%0d idle=%0d npc=%h st=%0d done=%b, expected cyc=%0d ins=%0d idle=%0d npc=%h st=%0d done=%b",
                             $time, cycle_count, instr_count, idle_count, last_npc, status, done,
                             e.cyc, e.ins, e.idl, e.npc, e.st, e.dn);
                end
            end
        end
    end

    initial begin
        int burst;
        bit rs, cs, ss;
        logic [1:0] v, h, il;
        burst = 0;
        start = 0; clear = 0; rst = 1;
        retire_valid = '0; retire_halt = '0; retire_illegal = '0; retire_npc = '0;

        // Reset, then 10 idle RUN cycles
        step(0, 0, 1, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, 0, '0);
        chk("reset cycle_count", cycle_count, 0);
        chk("reset last_npc", last_npc, 0);
        chk("reset status", status, 0);
        chk("reset done", done, 0);
        step(1, 0, 0, 0, 0, 0, '0);
        chk("after start cycle_count", cycle_count, 0);
        idle_n(10);
        chk("idle10 cycle_count", cycle_count, 10);
        chk("idle10 instr_count", instr_count, 0);
        chk("idle10 idle_count", idle_count, 10);
        chk("idle10 done", done, 0);

        // Multi-slot: 4x both slots, 1x slot 0 (NPC 0x40), then slot 1 halts -> 8+1+2 = 11
        step(0, 1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 0, '0);
        repeat (4) step(0, 0, 0, 2'b11, 0, 0, {64'h18, 64'h14});
        step(0, 0, 0, 2'b01, 0, 0, {64'h0, 64'h40});
        chk("multi npc after 01", last_npc, 64'h40);
        chk("multi done before halt", done, 0);
        step(0, 0, 0, 2'b11, 2'b10, 0, {64'h99, 64'h44});
        chk("multi instr_count", instr_count, 11);
        chk("multi cycle_count", cycle_count, 6);
        chk("multi status", status, 1);
        chk("multi done", done, 1);
        chk("multi last_npc", last_npc, 64'h99);

        // Halt ordering: slot 0 halts, so slot 1 is not counted
        step(0, 1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 2'b11, 2'b01, 0, {64'h200, 64'h100});
        chk("order instr_count", instr_count, 1);
        chk("order status", status, 1);
        chk("order last_npc", last_npc, 64'h100);

        // Illegal takes precedence over halt. DONE ignores start; clear zeroes everything.
        step(0, 1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 0, '0);
        repeat (2) step(0, 0, 0, 2'b01, 0, 0, {64'h0, 64'h8});
        step(0, 0, 0, 2'b01, 2'b01, 2'b01, {64'h0, 64'hC});
        chk("illegal status", status, 2);
        chk("illegal instr_count", instr_count, 3);
        repeat (3) step(1, 0, 0, 2'b11, 0, 0, '1);
        chk("done hold done", done, 1);
        chk("done hold instr_count", instr_count, 3);
        step(0, 1, 0, 0, 0, 0, '0);
        chk("clear cycle_count", cycle_count, 0);
        chk("clear instr_count", instr_count, 0);
        chk("clear idle_count", idle_count, 0);
        chk("clear last_npc", last_npc, 0);
        chk("clear done", done, 0);
        chk("clear status", status, 0);

        // Saturation at 8-bit counters
        step(1, 0, 0, 0, 0, 0, '0);
        repeat (300) step(0, 0, 0, 2'b11, 0, 0, {64'h2, 64'h1});
        chk("sat cycle_count", cycle_count, 255);
        chk("sat instr_count", instr_count, 255);
        chk("sat done", done, 0);

        // Watchdog boundary: 15 idle cycles and a retire do not expire it; 16 idle cycles do.
        step(0, 1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 2'b01, 0, 0, {64'h0, 64'h500});
        idle_n(15);
        step(0, 0, 0, 2'b01, 0, 0, {64'h0, 64'h504});
        chk("wd15 done", done, 0);
        idle_n(16);
`ifdef RETIRE_MON_WATCHDOG_EN
        chk("wd16 done", done, 1);
        chk("wd16 status", status, 3);
        chk("wd16 idle_count", idle_count, 31);
`else
        chk("nowd16 done", done, 0);
        idle_n(100);
        chk("nowd100 done", done, 0);
        chk("nowd100 status", status, 0);
`endif

        // Randomized traffic checked by the scoreboard
        step(0, 1, 0, 0, 0, 0, '0);
        for (int k = 0; k < 1500; k++) begin
            rs = ($urandom_range(0, 149) == 0);
            cs = ($urandom_range(0, 59) == 0);
            ss = ($urandom_range(0, 2) == 0);
            v  = 2'($urandom);
            for (int s = 0; s < RET_W; s++) begin
                h[s]  = ($urandom_range(0, 19) == 0);
                il[s] = ($urandom_range(0, 29) == 0);
            end
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(10, 24);
            if (burst > 0) begin v = 2'b00; burst--; end
            step(ss, cs, rs, v, h, il, {$urandom, $urandom, $urandom, $urandom});
        end

        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
